// File: rtl/stage_db_pkg.sv
// Shared sizing defaults and FSM encoding for the stage-database collector.
// No logic; imported by the collector top and its record buffer.
package stage_db_pkg;

    localparam int DEF_DATA_WIDTH               = 12;
    localparam int DEF_NUM_CLASSIFIERS_STAGE    = 10;
    localparam int DEF_NUM_PARAM_PER_CLASSIFIER = 19;
    localparam int DEF_NUM_STAGE_THRESHOLD      = 3;
    localparam int DEF_IDX_WIDTH                = 10;

    localparam int NUM_DATABASE_INDEX =
        DEF_NUM_CLASSIFIERS_STAGE * DEF_NUM_PARAM_PER_CLASSIFIER + DEF_NUM_STAGE_THRESHOLD;
    localparam int RECORD_WIDTH = DEF_NUM_PARAM_PER_CLASSIFIER * DEF_DATA_WIDTH;

    typedef enum logic [1:0] {
        S_CLASSIFIER = 2'd0,
        S_STAGE      = 2'd1,
        S_DONE       = 2'd2
    } state_e;

    // Counter width that stays legal when a count of one is configured.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/stage_db_record_buffer.sv
// Two-entry (assembly + output) classifier record buffer with overflow detect.
// Latency: completed record appears on rec_vld_o one cycle after its last word.
// Backpressure: rec_rdy_i stalls output; with both entries full, words are dropped and flagged.
module stage_db_record_buffer
    import stage_db_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_PARAM  = DEF_NUM_PARAM_PER_CLASSIFIER,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
    parameter int PIDX_WIDTH = clog2_min1(NUM_PARAM)
) (
    input  logic                            clk_fpga,
    input  logic                            reset_fpga,
    input  logic                            clear_i,
    input  logic                            word_vld_i,
    input  logic [DATA_WIDTH-1:0]           word_dat_i,
    input  logic [PIDX_WIDTH-1:0]           word_idx_i,
    input  logic                            word_last_i,
    input  logic [IDX_WIDTH-1:0]            word_tree_i,
    output logic                            word_acc_o,
    output logic                            asm_full_o,
    output logic                            overflow_o,
    output logic                            rec_vld_o,
    input  logic                            rec_rdy_i,
    output logic [NUM_PARAM*DATA_WIDTH-1:0] rec_dat_o,
    output logic [IDX_WIDTH-1:0]            rec_tree_o
);

    localparam int RW = NUM_PARAM * DATA_WIDTH;

    logic [RW-1:0]        asm_q, asm_d, out_q, out_d;
    logic [IDX_WIDTH-1:0] asm_tree_q, asm_tree_d, out_tree_q, out_tree_d;
    logic                 asm_full_q, asm_full_d, out_vld_q, out_vld_d;
    logic                 ovf_q, ovf_d;
    logic                 xfer, out_free, blocked, complete;

    assign xfer       = out_vld_q & rec_rdy_i;
    assign out_free   = ~out_vld_q | xfer;
    assign blocked    = asm_full_q & ~out_free;
    assign word_acc_o = word_vld_i & ~blocked;
    assign complete   = word_acc_o & word_last_i;

    always_comb begin
        asm_d      = asm_q;
        asm_tree_d = asm_tree_q;
        asm_full_d = asm_full_q;
        out_d      = out_q;
        out_tree_d = out_tree_q;
        out_vld_d  = out_vld_q;
        ovf_d      = ovf_q | (word_vld_i & blocked);

        for (int k = 0; k < NUM_PARAM; k++) begin
            if (word_acc_o && (word_idx_i == PIDX_WIDTH'(k))) begin
                asm_d[k*DATA_WIDTH +: DATA_WIDTH] = word_dat_i;
            end
        end

        if (xfer) begin
            out_vld_d = 1'b0;
        end
        // A pending record moves out while a new word may land in slot 0.
        if (asm_full_q && out_free) begin
            out_d      = asm_q;
            out_tree_d = asm_tree_q;
            out_vld_d  = 1'b1;
            asm_full_d = 1'b0;
        end
        // The completing word bypasses straight to the output when it can.
        if (complete) begin
            if (out_free && !asm_full_q) begin
                out_d      = asm_d;
                out_tree_d = word_tree_i;
                out_vld_d  = 1'b1;
            end else begin
                asm_full_d = 1'b1;
                asm_tree_d = word_tree_i;
            end
        end

        if (clear_i) begin
            asm_d      = '0;
            asm_tree_d = '0;
            asm_full_d = 1'b0;
            out_d      = '0;
            out_tree_d = '0;
            out_vld_d  = 1'b0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            asm_q      <= '0;
            asm_tree_q <= '0;
            asm_full_q <= 1'b0;
            out_q      <= '0;
            out_tree_q <= '0;
            out_vld_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            asm_tree_q <= asm_tree_d;
            asm_full_q <= asm_full_d;
            out_q      <= out_d;
            out_tree_q <= out_tree_d;
            out_vld_q  <= out_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign asm_full_o = asm_full_q;
    assign overflow_o = ovf_q;
    assign rec_vld_o  = out_vld_q;
    assign rec_dat_o  = out_q;
    assign rec_tree_o = out_tree_q;

endmodule

// File: rtl/stage_database_collector.sv
// Assembles serial stage-database words into per-classifier records plus stage words (optional STAGE_DB_CHECKSUM_EN).
// Latency: record valid one cycle after its last word when the output entry is free.
// Backpressure: none upstream; i_rec_ready stalls records, excess words dropped and flagged.
module stage_database_collector
    import stage_db_pkg::*;
#(
    parameter int DATA_WIDTH               = DEF_DATA_WIDTH,
    parameter int NUM_CLASSIFIERS_STAGE    = DEF_NUM_CLASSIFIERS_STAGE,
    parameter int NUM_PARAM_PER_CLASSIFIER = DEF_NUM_PARAM_PER_CLASSIFIER,
    parameter int NUM_STAGE_THRESHOLD      = DEF_NUM_STAGE_THRESHOLD,
    parameter int IDX_WIDTH                = DEF_IDX_WIDTH
) (
    input  logic                                           clk_fpga,
    input  logic                                           reset_fpga,
    input  logic                                           i_start,
    input  logic                                           i_valid,
    input  logic [DATA_WIDTH-1:0]                          i_data,
    output logic                                           o_rec_valid,
    input  logic                                           i_rec_ready,
    output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH-1:0] o_rec_data,
    output logic [IDX_WIDTH-1:0]                           o_rec_tree_index,
    output logic                                           o_stage_valid,
    output logic [DATA_WIDTH-1:0]                          o_stage_threshold,
    output logic [DATA_WIDTH-1:0]                          o_parent,
    output logic [DATA_WIDTH-1:0]                          o_next,
    output logic                                           o_done,
    output logic                                           o_overflow,
    output logic                                           o_error,
    output logic [DATA_WIDTH-1:0]                          o_checksum
);

    localparam int PIDX_WIDTH = clog2_min1(NUM_PARAM_PER_CLASSIFIER);
    localparam int SIDX_WIDTH = clog2_min1(NUM_STAGE_THRESHOLD);

    state_e                state_q, state_d;
    logic [PIDX_WIDTH-1:0] param_idx_q, param_idx_d;
    logic [IDX_WIDTH-1:0]  tree_idx_q, tree_idx_d;
    logic [SIDX_WIDTH-1:0] stage_idx_q, stage_idx_d;
    logic [DATA_WIDTH-1:0] thr_q, thr_d, parent_q, parent_d, next_q, next_d;
    logic                  stage_vld_q, stage_vld_d;
    logic                  error_q, error_d, done_q, done_d;

    logic in_cls, in_stage, in_done;
    logic word_vld, cls_vld, cls_acc, stage_acc;
    logic param_last, tree_last, stage_last;
    logic asm_full, rec_vld;

    // i_start wins over a coincident word.
    assign word_vld   = i_valid & ~i_start;
    assign cls_vld    = word_vld & in_cls;
    assign stage_acc  = word_vld & in_stage;
    assign param_last = (param_idx_q == PIDX_WIDTH'(NUM_PARAM_PER_CLASSIFIER - 1));
    assign tree_last  = (tree_idx_q == IDX_WIDTH'(NUM_CLASSIFIERS_STAGE - 1));
    assign stage_last = (stage_idx_q == SIDX_WIDTH'(NUM_STAGE_THRESHOLD - 1));

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state_q <= S_CLASSIFIER;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLASSIFIER: if (cls_acc && param_last && tree_last) state_d = S_STAGE;
            S_STAGE:      if (stage_acc && stage_last) state_d = S_DONE;
            S_DONE:       state_d = S_DONE;
            default:      state_d = S_CLASSIFIER;
        endcase
        if (i_start) begin
            state_d = S_CLASSIFIER;
        end
    end

    always_comb begin
        in_cls   = 1'b0;
        in_stage = 1'b0;
        in_done  = 1'b0;
        case (state_q)
            S_CLASSIFIER: in_cls   = 1'b1;
            S_STAGE:      in_stage = 1'b1;
            S_DONE:       in_done  = 1'b1;
            default:      in_cls   = 1'b0;
        endcase
    end

    always_comb begin
        param_idx_d = param_idx_q;
        tree_idx_d  = tree_idx_q;
        stage_idx_d = stage_idx_q;
        thr_d       = thr_q;
        parent_d    = parent_q;
        next_d      = next_q;
        stage_vld_d = stage_vld_q;
        error_d     = error_q | (word_vld & in_done);
        done_d      = in_done & stage_vld_q & ~rec_vld & ~asm_full;

        if (cls_acc) begin
            if (param_last) begin
                param_idx_d = '0;
                tree_idx_d  = tree_idx_q + IDX_WIDTH'(1);
            end else begin
                param_idx_d = param_idx_q + PIDX_WIDTH'(1);
            end
        end

        if (stage_acc) begin
            if (stage_idx_q == SIDX_WIDTH'(0)) thr_d    = i_data;
            if (stage_idx_q == SIDX_WIDTH'(1)) parent_d = i_data;
            if (stage_idx_q == SIDX_WIDTH'(2)) next_d   = i_data;
            if (stage_last) begin
                stage_vld_d = 1'b1;
            end else begin
                stage_idx_d = stage_idx_q + SIDX_WIDTH'(1);
            end
        end

        if (i_start) begin
            param_idx_d = '0;
            tree_idx_d  = '0;
            stage_idx_d = '0;
            thr_d       = '0;
            parent_d    = '0;
            next_d      = '0;
            stage_vld_d = 1'b0;
            error_d     = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            param_idx_q <= '0;
            tree_idx_q  <= '0;
            stage_idx_q <= '0;
            thr_q       <= '0;
            parent_q    <= '0;
            next_q      <= '0;
            stage_vld_q <= 1'b0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            param_idx_q <= param_idx_d;
            tree_idx_q  <= tree_idx_d;
            stage_idx_q <= stage_idx_d;
            thr_q       <= thr_d;
            parent_q    <= parent_d;
            next_q      <= next_d;
            stage_vld_q <= stage_vld_d;
            error_q     <= error_d;
            done_q      <= done_d;
        end
    end

    stage_db_record_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PARAM  (NUM_PARAM_PER_CLASSIFIER),
        .IDX_WIDTH  (IDX_WIDTH),
        .PIDX_WIDTH (PIDX_WIDTH)
    ) u_buf (
        .clk_fpga    (clk_fpga),
        .reset_fpga  (reset_fpga),
        .clear_i     (i_start),
        .word_vld_i  (cls_vld),
        .word_dat_i  (i_data),
        .word_idx_i  (param_idx_q),
        .word_last_i (param_last),
        .word_tree_i (tree_idx_q),
        .word_acc_o  (cls_acc),
        .asm_full_o  (asm_full),
        .overflow_o  (o_overflow),
        .rec_vld_o   (rec_vld),
        .rec_rdy_i   (i_rec_ready),
        .rec_dat_o   (o_rec_data),
        .rec_tree_o  (o_rec_tree_index)
    );

`ifdef STAGE_DB_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            sum_q <= '0;
        end else if (i_start) begin
            sum_q <= '0;
        end else if (cls_acc || stage_acc) begin
            sum_q <= sum_q + i_data;
        end
    end

    assign o_checksum = sum_q;
`else
    assign o_checksum = '0;
`endif

    assign o_rec_valid       = rec_vld;
    assign o_stage_valid     = stage_vld_q;
    assign o_stage_threshold = thr_q;
    assign o_parent          = parent_q;
    assign o_next            = next_q;
    assign o_done            = done_q;
    assign o_error           = error_q;

endmodule

// File: tb/tb_stage_database_collector.sv
// Self-checking bench for stage_database_collector against a record-queue reference model.
module tb_stage_database_collector;

    localparam int DW = 12;
    localparam int NC = 10;
    localparam int NP = 19;
    localparam int NS = 3;
    localparam int IW = 10;
    localparam int RW = NP * DW;

    logic          clk_fpga    = 1'b0;
    logic          reset_fpga  = 1'b1;
    logic          i_start     = 1'b0;
    logic          i_valid     = 1'b0;
    logic [DW-1:0] i_data      = '0;
    logic          i_rec_ready = 1'b0;
    logic          o_rec_valid;
    logic [RW-1:0] o_rec_data;
    logic [IW-1:0] o_rec_tree_index;
    logic          o_stage_valid;
    logic [DW-1:0] o_stage_threshold, o_parent, o_next;
    logic          o_done, o_overflow, o_error;
    logic [DW-1:0] o_checksum;

    stage_database_collector dut (
        .clk_fpga          (clk_fpga),
        .reset_fpga        (reset_fpga),
        .i_start           (i_start),
        .i_valid           (i_valid),
        .i_data            (i_data),
        .o_rec_valid       (o_rec_valid),
        .i_rec_ready       (i_rec_ready),
        .o_rec_data        (o_rec_data),
        .o_rec_tree_index  (o_rec_tree_index),
        .o_stage_valid     (o_stage_valid),
        .o_stage_threshold (o_stage_threshold),
        .o_parent          (o_parent),
        .o_next            (o_next),
        .o_done            (o_done),
        .o_overflow        (o_overflow),
        .o_error           (o_error),
        .o_checksum        (o_checksum)
    );

    always #5 clk_fpga = ~clk_fpga;

    int errors = 0;
    int checks = 0;

    // Reference model: completed records wait in a queue of depth two.
    logic [RW-1:0] m_part;
    int            m_pidx, m_tree, m_stage, m_sum;
    logic          m_ovf, m_err;
    logic [DW-1:0] m_sw [NS];
    logic [RW-1:0] m_pend[$];
    int            m_pend_tree[$];
    logic [RW-1:0] m_exp[$];
    int            m_exp_tree[$];
    logic [RW-1:0] got[$];
    int            got_tree[$];
    int            mon_bad;

    task automatic m_clear();
        m_part = '0; m_pidx = 0; m_tree = 0; m_stage = 0; m_sum = 0;
        m_ovf = 1'b0; m_err = 1'b0;
        for (int i = 0; i < NS; i++) m_sw[i] = '0;
        m_pend.delete(); m_pend_tree.delete();
        m_exp.delete(); m_exp_tree.delete();
        got.delete(); got_tree.delete();
        mon_bad = 0;
    endtask

    function automatic logic [RW-1:0] rec_of(input int base);
        logic [RW-1:0] r;
        for (int k = 0; k < NP; k++) r[k*DW +: DW] = DW'(base + k);
        return r;
    endfunction

    // Drive one cycle, observe away from the edge, then advance the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic st);
        logic xfer, blocked;
        i_valid = v; i_data = d; i_rec_ready = r; i_start = st;
        @(negedge clk_fpga);
        if (o_rec_valid !== (m_pend.size() > 0)) mon_bad++;
        else if (o_rec_valid && ((o_rec_data !== m_pend[0]) ||
                 (o_rec_tree_index !== IW'(m_pend_tree[0])))) mon_bad++;
        if ((o_rec_valid === 1'b1) && r) begin
            got.push_back(o_rec_data);
            got_tree.push_back(int'(o_rec_tree_index));
        end
        if (st) begin
            m_clear();
        end else begin
            xfer    = (m_pend.size() > 0) && r;
            blocked = (m_pend.size() == 2) && !xfer;
            if (v) begin
                if (m_tree < NC) begin
                    if (blocked) m_ovf = 1'b1;
                    else begin
                        m_part[m_pidx*DW +: DW] = d;
                        m_sum += int'(d);
                        m_pidx++;
                        if (m_pidx == NP) begin
                            m_pend.push_back(m_part);
                            m_pend_tree.push_back(m_tree);
                            m_tree++;
                            m_pidx = 0;
                        end
                    end
                end else if (m_stage < NS) begin
                    m_sw[m_stage] = d;
                    m_sum += int'(d);
                    m_stage++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (xfer) begin
                m_exp.push_back(m_pend.pop_front());
                m_exp_tree.push_back(m_pend_tree.pop_front());
            end
        end
        @(posedge clk_fpga);
        #1;
        i_start = 1'b0;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, '0, r, 1'b0);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (o_rec_valid !== 1'b0) begin errors++; $display("FAIL reset_rec_valid: got %b expected 0", o_rec_valid); end
        checks++; if (o_rec_data !== '0 || o_rec_tree_index !== '0) begin errors++; $display("FAIL reset_rec_data: got %h/%0d expected 0", o_rec_data, o_rec_tree_index); end
        checks++; if ({o_stage_valid, o_done, o_overflow, o_error} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {o_stage_valid, o_done, o_overflow, o_error}); end
        checks++; if ({o_stage_threshold, o_parent, o_next, o_checksum} !== '0) begin errors++; $display("FAIL reset_stage_regs: got %h expected 0", {o_stage_threshold, o_parent, o_next, o_checksum}); end
        @(posedge clk_fpga); #1;
        reset_fpga = 1'b0;
        m_clear();
    endtask

    task automatic check_stage_end(input string tag, input logic [DW-1:0] t, input logic [DW-1:0] p,
                                   input logic [DW-1:0] n, input logic ovf);
        logic [DW-1:0] ck;
`ifdef STAGE_DB_CHECKSUM_EN
        ck = DW'(m_sum);
`else
        ck = '0;
`endif
        checks++; if ({o_stage_threshold, o_parent, o_next} !== {t, p, n}) begin errors++; $display("FAIL %s_stage_words: got %0d %0d %0d expected %0d %0d %0d", tag, o_stage_threshold, o_parent, o_next, t, p, n); end
        checks++; if ({o_stage_valid, o_done, o_error} !== 3'b110) begin errors++; $display("FAIL %s_done_flags: got %b expected 110", tag, {o_stage_valid, o_done, o_error}); end
        checks++; if (o_overflow !== ovf) begin errors++; $display("FAIL %s_overflow: got %b expected %b", tag, o_overflow, ovf); end
        checks++; if (o_checksum !== ck) begin errors++; $display("FAIL %s_checksum: got %h expected %h", tag, o_checksum, ck); end
        checks++; if (mon_bad !== 0) begin errors++; $display("FAIL %s_record_stream: got %0d bad cycles expected 0", tag, mon_bad); end
    endtask

    task automatic test_full_rate();
        logic [DW-1:0] ck;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < NC*NP + NS; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        idle(5, 1'b1);
        checks++; if (got.size() !== NC) begin errors++; $display("FAIL full_rate_count: got %0d expected %0d", got.size(), NC); end
        for (int n = 0; n < got.size() && n < NC; n++) begin
            checks++;
            if (got[n] !== rec_of(NP*n) || got_tree[n] !== n) begin
                errors++; $display("FAIL full_rate_rec%0d: got tree %0d %h expected tree %0d %h", n, got_tree[n], got[n], n, rec_of(NP*n));
            end
        end
`ifdef STAGE_DB_CHECKSUM_EN
        ck = 12'h860;
`else
        ck = 12'h000;
`endif
        checks++; if (o_checksum !== ck) begin errors++; $display("FAIL full_rate_checksum_const: got %h expected %h", o_checksum, ck); end
        check_stage_end("full_rate", 12'd190, 12'd191, 12'd192, 1'b0);
    endtask

    task automatic test_error();
        step(1'b1, 12'hABC, 1'b1, 1'b0);
        idle(1, 1'b1);
        checks++; if (o_error !== m_err) begin errors++; $display("FAIL error_set: got %b expected %b", o_error, m_err); end
        checks++; if ({o_stage_threshold, o_parent, o_next} !== {12'd190, 12'd191, 12'd192}) begin errors++; $display("FAIL error_stage_kept: got %0d %0d %0d expected 190 191 192", o_stage_threshold, o_parent, o_next); end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++; if ({o_error, o_done, o_stage_valid} !== 3'b000) begin errors++; $display("FAIL error_cleared: got %b expected 000", {o_error, o_done, o_stage_valid}); end
    endtask

    task automatic test_no_ready();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < NC*NP + NS; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        checks++; if (o_rec_valid !== 1'b1 || o_rec_tree_index !== '0) begin errors++; $display("FAIL no_ready_hold: got vld %b tree %0d expected 1 0", o_rec_valid, o_rec_tree_index); end
        checks++; if (o_rec_data !== rec_of(0)) begin errors++; $display("FAIL no_ready_data: got %h expected %h", o_rec_data, rec_of(0)); end
        checks++; if (o_overflow !== 1'b1 || o_stage_valid !== 1'b0) begin errors++; $display("FAIL no_ready_overflow: got ovf %b stv %b expected 1 0", o_overflow, o_stage_valid); end
        idle(3, 1'b1);
        for (int j = 0; j < NP; j++) step(1'b1, DW'(1000 + j), 1'b1, 1'b0);
        idle(3, 1'b1);
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL no_ready_count: got %0d expected 3", got.size()); end
        else begin
            checks++; if (got[1] !== rec_of(NP) || got_tree[1] !== 1) begin errors++; $display("FAIL no_ready_rec1: got tree %0d %h expected tree 1 %h", got_tree[1], got[1], rec_of(NP)); end
            checks++; if (got[2] !== rec_of(1000) || got_tree[2] !== 2) begin errors++; $display("FAIL no_ready_resume: got tree %0d %h expected tree 2 %h", got_tree[2], got[2], rec_of(1000)); end
        end
        checks++; if (mon_bad !== 0) begin errors++; $display("FAIL no_ready_record_stream: got %0d bad cycles expected 0", mon_bad); end
    endtask

    task automatic test_stall();
        logic [RW-1:0] held;
        int seen, unstable, got_after, sent;
        logic r, probe;
        seen = 0; unstable = 0; got_after = -1; sent = 0; held = '0;
        step(1'b0, '0, 1'b0, 1'b1);
        while (sent < 3*NP) begin
            r = 1'b1; probe = 1'b0;
            if (o_rec_valid === 1'b1 && seen < 5) begin
                if (seen == 0) held = o_rec_data;
                else if (o_rec_data !== held) unstable++;
                r = 1'b0; seen++;
            end else if (seen == 5) begin
                probe = 1'b1; seen++;
            end
            step(1'b1, DW'(sent), r, 1'b0);
            sent++;
            if (probe) got_after = got.size();
        end
        idle(4, 1'b1);
        checks++; if (held !== rec_of(0) || unstable !== 0) begin errors++; $display("FAIL stall_stable: got %h changes %0d expected %h 0", held, unstable, rec_of(0)); end
        checks++; if (got_after !== 1) begin errors++; $display("FAIL stall_first_ready_xfer: got %0d records expected 1", got_after); end
        checks++; if (got.size() !== 3 || got_tree[0] !== 0) begin errors++; $display("FAIL stall_count: got %0d expected 3", got.size()); end
        checks++; if (mon_bad !== 0) begin errors++; $display("FAIL stall_record_stream: got %0d bad cycles expected 0", mon_bad); end
    endtask

    task automatic test_async_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b1, DW'(i + 7), 1'b0, 1'b0);
        #2 reset_fpga = 1'b1;
        #1;
        checks++; if (o_rec_valid !== 1'b0 || o_rec_data !== '0 || o_overflow !== 1'b0) begin errors++; $display("FAIL async_reset_clear: got vld %b data %h expected 0", o_rec_valid, o_rec_data); end
        @(posedge clk_fpga); #1;
        reset_fpga = 1'b0;
        m_clear();
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < NC*NP + NS; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        idle(5, 1'b1);
        checks++; if (got.size() !== NC) begin errors++; $display("FAIL async_reset_count: got %0d expected %0d", got.size(), NC); end
        else begin
            checks++; if (got_tree[0] !== 0 || got[0][DW-1:0] !== '0) begin errors++; $display("FAIL async_reset_first: got tree %0d p0 %0d expected 0 0", got_tree[0], got[0][DW-1:0]); end
        end
        check_stage_end("async_reset", 12'd190, 12'd191, 12'd192, 1'b0);
    endtask

    task automatic test_random();
        int cyc;
        logic v, r;
        cyc = 0;
        step(1'b0, '0, 1'b0, 1'b1);
        while (!(m_stage == NS && m_pend.size() == 0) && cyc < 4000) begin
            v = (m_stage < NS) && ($urandom_range(99) < 75);
            r = ($urandom_range(99) < 40);
            step(v, DW'($urandom), r, 1'b0);
            cyc++;
        end
        checks++; if (cyc >= 4000) begin errors++; $display("FAIL random_timeout: got %0d cycles expected < 4000", cyc); end
        idle(4, 1'b1);
        checks++; if (got.size() !== m_exp.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", got.size(), m_exp.size()); end
        for (int n = 0; n < got.size() && n < m_exp.size(); n++) begin
            checks++;
            if (got[n] !== m_exp[n] || got_tree[n] !== m_exp_tree[n]) begin
                errors++; $display("FAIL random_rec%0d: got tree %0d %h expected tree %0d %h", n, got_tree[n], got[n], m_exp_tree[n], m_exp[n]);
            end
        end
        check_stage_end("random", m_sw[0], m_sw[1], m_sw[2], m_ovf);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_rate();
        test_error();
        test_no_ready();
        test_stall();
        test_async_reset();
        for (int k = 0; k < 3; k++) test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
